// File: rtl/byte_lsu_if.sv
// ============================================================================
// byte_lsu_if : core request/response and byte-memory bus of the byte LSU
// Rev 1.0
// ============================================================================
`default_nettype none

interface byte_lsu_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_din
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_din
  );
endinterface

`default_nettype wire

// File: rtl/byte_lsu.sv
// ============================================================================
// byte_lsu : RV32I load/store unit driving a byte-wide synchronous data memory
// Rev 1.0
// ============================================================================
`default_nettype none

module byte_lsu #(
  parameter int ADDR_W = 10
) (
  input  wire logic     sysclk,
  input  wire logic     sysreset,
  byte_lsu_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_CAPT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_we;
  logic              r_sext;
  logic [1:0]        r_last;
  logic [1:0]        r_cnt;
  logic [23:0]       r_wdata;
  logic [31:0]       r_rbuf;
  logic              r_ready;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [7:0]        r_mem_din;

  logic              w_accept;
  logic              w_err;
  logic [1:0]        w_last;
  logic [31:0]       w_full;
  logic [31:0]       w_ext;
  logic              w_unused_addr;

  assign w_accept      = bus.req_valid & r_ready;
  assign w_unused_addr = ^bus.req_addr[31:ADDR_W];

  always_comb begin
    w_err  = 1'b0;
    w_last = 2'd0;
    case (bus.req_funct3)
      3'b000, 3'b100: w_last = 2'd0;
      3'b001, 3'b101: w_last = 2'd1;
      3'b010:         w_last = 2'd3;
      default:        w_err  = 1'b1;
    endcase
    if (bus.req_we && bus.req_funct3[2])
      w_err = 1'b1;
    if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
      w_err = 1'b1;
    if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)
      w_err = 1'b1;
  end

  // The final byte arrives in CAPT and is merged straight into the result.
  always_comb begin
    w_full = r_rbuf;
    case (r_cnt)
      2'd0:    w_full[7:0]   = bus.mem_dout;
      2'd1:    w_full[15:8]  = bus.mem_dout;
      2'd2:    w_full[23:16] = bus.mem_dout;
      default: w_full[31:24] = bus.mem_dout;
    endcase
    case (r_last)
      2'd0:    w_ext = {{24{r_sext & w_full[7]}}, w_full[7:0]};
      2'd1:    w_ext = {{16{r_sext & w_full[15]}}, w_full[15:0]};
      default: w_ext = w_full;
    endcase
  end

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_sext      <= 1'b0;
      r_last      <= 2'd0;
      r_cnt       <= 2'd0;
      r_wdata     <= 24'd0;
      r_rbuf      <= 32'd0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_din   <= 8'd0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            r_we    <= bus.req_we;
            r_sext  <= ~bus.req_funct3[2];
            r_last  <= w_last;
            r_cnt   <= 2'd0;
            r_rbuf  <= 32'd0;
            if (w_err) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= 32'd0;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state    <= S_XFER;
              r_mem_addr <= bus.req_addr[ADDR_W-1:0];
              r_mem_we   <= bus.req_we;
              r_mem_din  <= bus.req_we ? bus.req_wdata[7:0] : 8'd0;
              r_wdata    <= bus.req_wdata[31:8];
            end
          end
        end
        S_XFER: begin
          // Read data lags its address by one cycle, so byte r_cnt-1 is on mem_dout now.
          if (!r_we) begin
            case (r_cnt)
              2'd1:    r_rbuf[7:0]   <= bus.mem_dout;
              2'd2:    r_rbuf[15:8]  <= bus.mem_dout;
              2'd3:    r_rbuf[23:16] <= bus.mem_dout;
              default: r_rbuf        <= r_rbuf;
            endcase
          end
          if (r_cnt == r_last) begin
            r_mem_we  <= 1'b0;
            r_mem_din <= 8'd0;
            if (r_we) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= 32'd0;
              r_rsp_err   <= 1'b0;
            end else begin
              r_state <= S_CAPT;
            end
          end else begin
            r_cnt      <= r_cnt + 2'd1;
            r_mem_addr <= r_mem_addr + 1'b1;
            r_mem_din  <= r_we ? r_wdata[7:0] : 8'd0;
            r_wdata    <= {8'd0, r_wdata[23:8]};
          end
        end
        S_CAPT: begin
          r_state     <= S_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= w_ext;
          r_rsp_err   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_din   = r_mem_din;

endmodule

`default_nettype wire

// File: tb/tb_byte_lsu.sv
// ============================================================================
// tb_byte_lsu : directed self-checking bench for byte_lsu with a byte memory model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_byte_lsu;
  localparam int ADDR_W = 10;
  localparam int NCYC   = 10;

  logic sysclk   = 1'b0;
  logic sysreset = 1'b0;

  byte_lsu_if #(.ADDR_W(ADDR_W)) bus ();

  byte_lsu #(.ADDR_W(ADDR_W)) dut (
    .sysclk   (sysclk),
    .sysreset (sysreset),
    .bus      (bus)
  );

  always #5 sysclk = ~sysclk;

  // Byte memory with one-cycle synchronous read
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge sysclk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= mem[bus.mem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic              l_we    [0:NCYC];
  logic [ADDR_W-1:0] l_addr  [0:NCYC];
  logic [7:0]        l_din   [0:NCYC];
  logic              l_rv    [0:NCYC];
  logic              l_ready [0:NCYC+1];
  logic [31:0]       l_rdata [0:NCYC];
  logic              l_err   [0:NCYC];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int w = 0;
    while (bus.req_ready !== 1'b1 && w < 20) begin
      @(posedge sysclk); #1;
      w++;
    end
    if (w == 20) check("ready_timeout", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge sysclk); #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = 32'hFFFF_FFFF;
    bus.req_wdata  = 32'hA5A5_A5A5;
    for (int c = 1; c <= NCYC; c++) begin
      l_we[c]    = bus.mem_we;
      l_addr[c]  = bus.mem_addr;
      l_din[c]   = bus.mem_din;
      l_rv[c]    = bus.rsp_valid;
      l_ready[c] = bus.req_ready;
      l_rdata[c] = bus.rsp_rdata;
      l_err[c]   = bus.rsp_err;
      @(posedge sysclk); #1;
    end
    l_ready[NCYC+1] = bus.req_ready;
  endtask

  task automatic chk_resp(input string tag, input int exp_cyc, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_nw);
    int rc = 0, nrv = 0, nw = 0, nlow = 0;
    for (int c = 1; c <= NCYC; c++) begin
      if (l_rv[c]) begin
        nrv++;
        if (rc == 0) rc = c;
      end
      if (l_we[c]) nw++;
      if (c <= exp_cyc && !l_ready[c]) nlow++;
    end
    check({tag, "_rsp_cycle"}, rc, exp_cyc);
    check({tag, "_rsp_pulses"}, nrv, 1);
    check({tag, "_rdata"}, l_rdata[exp_cyc], exp_rdata);
    check({tag, "_err"}, {31'd0, l_err[exp_cyc]}, {31'd0, exp_err});
    check({tag, "_ready_low"}, nlow, exp_cyc);
    check({tag, "_ready_back"}, {31'd0, l_ready[exp_cyc+1]}, 32'd1);
    check({tag, "_nwrites"}, nw, exp_nw);
  endtask

  task automatic chk_write(input string tag, input int k, input logic [ADDR_W-1:0] addr,
                           input logic [7:0] din);
    check({tag, "_we"}, {31'd0, l_we[k+1]}, 32'd1);
    check({tag, "_addr"}, {22'd0, l_addr[k+1]}, {22'd0, addr});
    check({tag, "_din"}, {24'd0, l_din[k+1]}, {24'd0, din});
  endtask

  initial begin
    logic [31:0] word;
    int nrv;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    repeat (3) @(posedge sysclk);
    #1;
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rst_mem_addr", {22'd0, bus.mem_addr}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_mem_din", {24'd0, bus.mem_din}, 32'd0);
    sysreset = 1'b1;
    @(posedge sysclk); #1;

    word = 32'hDEAD_BEEF;
    issue(1'b1, 3'b010, 32'h10, word);
    chk_resp("sw", 5, 32'd0, 1'b0, 4);
    for (int k = 0; k < 4; k++)
      chk_write("sw_b", k, 10'(32'h10 + k), word[8*k +: 8]);
    check("sw_we_off", {31'd0, l_we[5]}, 32'd0);

    issue(1'b0, 3'b010, 32'h10, 32'd0);
    chk_resp("lw", 6, 32'hDEAD_BEEF, 1'b0, 0);

    issue(1'b1, 3'b000, 32'h20, 32'h1234_5680);
    chk_resp("sb20", 2, 32'd0, 1'b0, 1);
    chk_write("sb20_w", 0, 10'h20, 8'h80);
    issue(1'b1, 3'b000, 32'h21, 32'h0000_0090);
    chk_resp("sb21", 2, 32'd0, 1'b0, 1);

    issue(1'b0, 3'b000, 32'h20, 32'd0);
    chk_resp("lb", 3, 32'hFFFF_FF80, 1'b0, 0);
    issue(1'b0, 3'b100, 32'h20, 32'd0);
    chk_resp("lbu", 3, 32'h0000_0080, 1'b0, 0);
    issue(1'b0, 3'b001, 32'h20, 32'd0);
    chk_resp("lh", 4, 32'hFFFF_9080, 1'b0, 0);
    issue(1'b0, 3'b101, 32'h20, 32'd0);
    chk_resp("lhu", 4, 32'h0000_9080, 1'b0, 0);

    issue(1'b0, 3'b001, 32'h21, 32'd0);
    chk_resp("err_lh_mis", 1, 32'd0, 1'b1, 0);
    issue(1'b1, 3'b010, 32'h22, 32'hFFFF_FFFF);
    chk_resp("err_sw_mis", 1, 32'd0, 1'b1, 0);
    issue(1'b1, 3'b100, 32'h30, 32'h0000_0011);
    chk_resp("err_sbu", 1, 32'd0, 1'b1, 0);
    issue(1'b0, 3'b011, 32'h40, 32'd0);
    chk_resp("err_f3_011", 1, 32'd0, 1'b1, 0);

    issue(1'b1, 3'b000, 32'h3FF, 32'h0000_0055);
    chk_resp("sb_top", 2, 32'd0, 1'b0, 1);
    chk_write("sb_top_w", 0, 10'h3FF, 8'h55);
    issue(1'b1, 3'b001, 32'h3FC, 32'h0000_2211);
    chk_resp("sh_3fc", 3, 32'd0, 1'b0, 2);
    chk_write("sh_3fc_w1", 1, 10'h3FD, 8'h22);
    issue(1'b1, 3'b000, 32'h3FE, 32'h0000_0033);
    chk_resp("sb_3fe", 2, 32'd0, 1'b0, 1);
    issue(1'b0, 3'b010, 32'h3FC, 32'd0);
    chk_resp("lw_top", 6, 32'h5533_2211, 1'b0, 0);

    // Abort a store mid-transfer with an asynchronous reset
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h50;
    bus.req_wdata  = 32'h1234_5678;
    @(posedge sysclk); #1;
    bus.req_valid = 1'b0;
    @(posedge sysclk); #1;
    check("abort_pre_we", {31'd0, bus.mem_we}, 32'd1);
    #2 sysreset = 1'b0;
    #1;
    check("abort_we", {31'd0, bus.mem_we}, 32'd0);
    check("abort_ready", {31'd0, bus.req_ready}, 32'd1);
    check("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("abort_mem_addr", {22'd0, bus.mem_addr}, 32'd0);
    check("abort_mem_din", {24'd0, bus.mem_din}, 32'd0);
    @(negedge sysclk);
    sysreset = 1'b1;
    nrv = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge sysclk); #1;
      if (bus.rsp_valid) nrv++;
    end
    check("abort_no_rsp", nrv, 0);
    issue(1'b0, 3'b000, 32'h20, 32'd0);
    chk_resp("lb_after_rst", 3, 32'hFFFF_FF80, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
